fpu_seq_issue: RTL and testbench
================================

Name: fpu_seq_issue

Overview:
- Request sequencer that sits directly upstream of fpu_arith.
- Buffers FP operation requests from the issue logic in a small FIFO and launches them one at a time using fpu_arith's start/ready protocol (one-cycle start pulse, operands held, wait for ready).
- Captures the result and exception flags, and presents them as a tagged valid/ready response.
- Only one operation is in flight in the FPU at any time.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, ≥2.
- TAG_W, 6, request tag width returned with the response.
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit (used only with FPU_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept a request
- req_opa  in  32  operand A
- req_opb  in  32  operand B
- req_op  in  3  fpu_op_i encoding
- req_rmode  in  2  rounding mode
- req_tag  in  TAG_W  request tag
- fpu_start  out  1  to fpu_arith start_i
- fpu_opa  out  32  to opa_i
- fpu_opb  out  32  to opb_i
- fpu_op  out  3  to fpu_op_i
- fpu_rmode  out  2  to rmode_i
- fpu_ready  in  1  from ready_o
- fpu_result  in  32  from output_o
- fpu_flags  in  8  {ine, overflow, underflow, div_zero, inf, zero, qnan, snan}
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  result
- rsp_flags  out  8  captured flags
- rsp_tag  out  TAG_W  tag of completed request
- rsp_timeout  out  1  response produced by watchdog abort
- busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Reset: all outputs 0, FIFO empty (count=0), state=IDLE. Asserting rst mid-operation discards all queued and in-flight work; any later fpu_ready is ignored until a new ISSUE occurs.
- FIFO:
  - Push when req_valid && req_ready; req_ready = (count < DEPTH), independent of the pop in the same cycle.
  - Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
  - Simultaneous push and pop: count unchanged.
  - Pop occurs only on the IDLE->ISSUE transition.
- FSM (IDLE, ISSUE, WAIT, RESP):
  - IDLE: if count>0, pop the head into the fpu_* operand registers, tag register := head tag; next state ISSUE.
  - ISSUE: fpu_start=1 for exactly this cycle; next state WAIT.
  - WAIT: fpu_start=0. fpu_ready is sampled only in WAIT, never in the ISSUE cycle. On fpu_ready=1, capture rsp_data, rsp_flags, rsp_tag; set rsp_valid=1 and rsp_timeout=0; next state RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. When rsp_ready=1, rsp_valid goes 0 next cycle; next state IDLE.
- fpu_opa/opb/op/rmode are registered and held constant from ISSUE until the next pop.
- Latency (empty FIFO, idle FSM):
  - Request accepted at cycle N; IDLE pops at N+1; fpu_start=1 at N+2.
  - If fpu_ready is first seen high at cycle M (M ≥ N+3), rsp_valid=1 at M+1.
  - Back-to-back throughput: the cycle after the response handshake is IDLE; the next fpu_start follows 2 cycles later.
- A push into an empty FIFO while the FSM is in IDLE is not visible until the following cycle, since count is registered.

Optional Feature:
- Macro FPU_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no fpu_ready: rsp_data=32'h7FC00000, rsp_flags=8'h02 (qnan), rsp_timeout=1; go to RESP.
  - A late fpu_ready from the aborted operation arriving outside WAIT is ignored.
- Not defined: no counter; WAIT is held indefinitely; rsp_timeout tied 0.

Test Plan:
- Single op: req opa=32'h3F800000, opb=32'h40000000, op=3'd2, rmode=0, tag=5; FPU model ready 6 cycles after start with result 32'h40000000 -> exactly one fpu_start pulse; rsp_valid with data 32'h40000000, tag 5, flags 0, one cycle after ready.
- Fill: 5 requests with rsp_ready=1 and FPU latency 20 -> req_ready=0 once 4 are queued behind the in-flight op; responses are returned in tag order 0..4; no push occurs while count=DEPTH.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data/flags/tag stable, no new fpu_start; the next op issues 2 cycles after the handshake.
- Flags: FPU returns result 32'h7F800000 with flags 8'h48 (overflow, inf) -> rsp_flags=8'h48; a ready pulse coincident with the ISSUE cycle is not taken as completion.
- Reset mid-WAIT with 3 queued -> all outputs 0, busy=0, count=0; a stale fpu_ready after reset produces no response.
- FPU_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=8 and an FPU model that never answers -> rsp_valid 9 cycles after fpu_start with data 32'h7FC00000, flags 8'h02, rsp_timeout=1; the next queued op then proceeds normally.

Source files
------------

// File: rtl/fpu_seq_issue.sv
// ---------------------------------------------------------------------------
// fpu_seq_issue -- request sequencer in front of fpu_arith.
//
// Queues FP operation requests in a small FIFO and launches them one at a
// time on fpu_arith's start/ready handshake: a one-cycle start pulse with the
// operands held on registered outputs, then a wait for ready. The result and
// exception flags are captured and returned as a tagged valid/ready response.
// Only one operation is ever in flight inside the FPU.
//
// Optional feature: define FPU_SEQ_TIMEOUT_EN to add a WAIT-state watchdog.
// After TIMEOUT_CYCLES WAIT cycles without fpu_ready, a quiet-NaN response
// (flags = qnan) with rsp_timeout=1 is produced. Without the macro the
// sequencer waits forever and rsp_timeout is tied low.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req_*             request in (valid/ready): opa, opb, op, rmode, tag
//   fpu_start         one-cycle launch pulse to fpu_arith
//   fpu_opa/opb/op/rmode  registered operands, held until the next pop
//   fpu_ready         completion from fpu_arith (only looked at in WAIT)
//   fpu_result/flags  result and {ine,ovf,unf,dz,inf,zero,qnan,snan}
//   rsp_*             response out (valid/ready): data, flags, tag, timeout
//   busy              FIFO non-empty or sequencer not idle
// ---------------------------------------------------------------------------
module fpu_seq_issue #(
  parameter int DEPTH          = 4,
  parameter int TAG_W          = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_opa,
  input  logic [31:0]      req_opb,
  input  logic [2:0]       req_op,
  input  logic [1:0]       req_rmode,
  input  logic [TAG_W-1:0] req_tag,
  // fpu_arith side
  output logic             fpu_start,
  output logic [31:0]      fpu_opa,
  output logic [31:0]      fpu_opb,
  output logic [2:0]       fpu_op,
  output logic [1:0]       fpu_rmode,
  input  logic             fpu_ready,
  input  logic [31:0]      fpu_result,
  input  logic [7:0]       fpu_flags,
  // response side
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [7:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [7:0]  QNAN_FLAG = 8'h02;

  // Bad configurations stop elaboration instead of building a broken FIFO.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fpu_seq_issue: DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef struct packed {
    logic [31:0]      opa;
    logic [31:0]      opb;
    logic [2:0]       op;
    logic [1:0]       rmode;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  req_t             fifo_mem [DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, done, wd_expire;
  logic [TAG_W-1:0] tag_q;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  // req_ready looks only at the registered count, never at a same-cycle pop,
  // so a full FIFO refuses a push even while the head is leaving. It is held
  // low while reset is asserted so every output reads 0 during reset.
  assign req_ready = !rst && (count < CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign head      = fifo_mem[rd_ptr];

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{opa: req_opa, opb: req_opb, op: req_op,
                                    rmode: req_rmode, tag: req_tag};
  end

  // DEPTH is a power of 2, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // fpu_ready is only honoured in WAIT: a pulse during ISSUE, or a late answer
  // from an aborted or reset-discarded operation, never completes anything.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (fpu_ready || wd_expire) begin
          done    = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fpu_start = (state_q == S_ISSUE);
  assign busy      = (count != '0) || (state_q != S_IDLE);

  // Operands are loaded at the pop and stay put through ISSUE and WAIT, as
  // fpu_arith expects them stable for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_opa   <= '0;
      fpu_opb   <= '0;
      fpu_op    <= '0;
      fpu_rmode <= '0;
      tag_q     <= '0;
    end else if (pop) begin
      fpu_opa   <= head.opa;
      fpu_opb   <= head.opb;
      fpu_op    <= head.op;
      fpu_rmode <= head.rmode;
      tag_q     <= head.tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  // A real answer wins over a watchdog expiry landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_tag   <= '0;
    end else if (done) begin
      rsp_valid <= 1'b1;
      rsp_data  <= fpu_ready ? fpu_result : QNAN;
      rsp_flags <= fpu_ready ? fpu_flags  : QNAN_FLAG;
      rsp_tag   <= tag_q;
    end else if (state_q == S_RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // WAIT watchdog
  // ---------------------------------------------------------------------------
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Held at 0 outside WAIT, so it is already clear on entry. It reads k on
  // the (k+1)-th WAIT cycle; expiring at TIMEOUT_CYCLES-1 means the abort
  // lands after exactly TIMEOUT_CYCLES WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wd_cnt <= '0;
    else if (state_q != S_WAIT) wd_cnt <= '0;
    else                        wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expire = (state_q == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rsp_timeout <= 1'b0;
    else if (done) rsp_timeout <= !fpu_ready;
  end
`else
  assign wd_expire   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_seq_issue.sv
// ---------------------------------------------------------------------------
// tb_fpu_seq_issue -- directed bench for fpu_seq_issue.
// A single process drives inputs and observes outputs at the falling edge.
// A small FPU model answers a set number of cycles after fpu_start, with a
// fixed result or opa+1. Compile with FPU_SEQ_TIMEOUT_EN to add the
// watchdog scenario (TIMEOUT_CYCLES=8).
// ---------------------------------------------------------------------------
module tb_fpu_seq_issue;
  localparam int TAG_W = 6;
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int FILL_LAT = 6;   // must stay under the 8-cycle watchdog
`else
  localparam int FILL_LAT = 20;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0, req_ready;
  logic [31:0]      req_opa = '0, req_opb = '0;
  logic [2:0]       req_op = '0;
  logic [1:0]       req_rmode = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             fpu_start;
  logic [31:0]      fpu_opa, fpu_opb;
  logic [2:0]       fpu_op;
  logic [1:0]       fpu_rmode;
  logic             fpu_ready = 1'b0;
  logic [31:0]      fpu_result = '0;
  logic [7:0]       fpu_flags = '0;
  logic             rsp_valid, rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [7:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout, busy;

  fpu_seq_issue #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opa(req_opa),
    .req_opb(req_opb), .req_op(req_op), .req_rmode(req_rmode), .req_tag(req_tag),
    .fpu_start(fpu_start), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op),
    .fpu_rmode(fpu_rmode), .fpu_ready(fpu_ready), .fpu_result(fpu_result),
    .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, n_start = 0, last_start = 0, n_push = 0, n_rsp = 0, hs_cyc = 0;
  logic [TAG_W-1:0] got_tag  [64];
  logic [31:0]      got_data [64];
  // FPU model
  bit          m_en = 1'b0, m_fix = 1'b0;
  int          m_lat = 1, m_cnt = 0;
  logic [31:0] m_res = '0, m_opa = '0;
  logic [7:0]  m_flg = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Handshakes are recorded before the edge that samples them; fpu_start and
  // the FPU model are handled just after the next falling edge.
  task automatic tick();
    if (req_valid && req_ready) n_push++;
    if (rsp_valid && rsp_ready) begin
      if (n_rsp < 64) begin
        got_tag[n_rsp]  = rsp_tag;
        got_data[n_rsp] = rsp_data;
      end
      n_rsp++;
      hs_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
    fpu_ready = 1'b0;
    if (fpu_start) begin
      n_start++;
      last_start = cyc;
    end
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        fpu_ready  = 1'b1;
        fpu_result = m_fix ? m_res : m_opa + 32'd1;
        fpu_flags  = m_flg;
      end
    end
    if (fpu_start && m_en) begin
      m_cnt = m_lat;
      m_opa = fpu_opa;
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [1:0] rm, input logic [TAG_W-1:0] tg);
    int np;
    np = n_push;
    req_opa = a; req_opb = b; req_op = op; req_rmode = rm; req_tag = tg;
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (n_push != np) break;
    end
    req_valid = 1'b0;
    if (n_push == np) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_start(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (fpu_start) return;
      tick();
    end
    chk("start_timeout", 0, 1);
  endtask

  task automatic wait_rv(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (rsp_valid) return;
      tick();
    end
    chk("rsp_timeout_wait", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t0, s0, r0, h, np;
    bit ok;

    // ---- reset state ----
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_fpu_start", fpu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_req_ready", req_ready, 1);

    // ---- single op: ready 6 cycles after start, response one cycle later ----
    m_en = 1; m_fix = 1; m_res = 32'h4000_0000; m_flg = 8'h00; m_lat = 6;
    rsp_ready = 0;
    s0 = n_start;
    push_req(32'h3F80_0000, 32'h4000_0000, 3'd2, 2'd0, 6'd5);
    t0 = cyc;                               // accept cycle N plus one
    wait_start(10);
    chk("t1_start_lat", cyc - t0, 1);       // start at N+2
    chk("t1_opa", fpu_opa, 32'h3F80_0000);
    chk("t1_opb", fpu_opb, 32'h4000_0000);
    chk("t1_op", fpu_op, 3'd2);
    wait_rv(30);
    chk("t1_rsp_lat", cyc - last_start, 7);
    chk("t1_data", rsp_data, 32'h4000_0000);
    chk("t1_tag", rsp_tag, 5);
    chk("t1_flags", rsp_flags, 0);
    chk("t1_tmo", rsp_timeout, 0);
    chk("t1_one_start", n_start - s0, 1);
    rsp_ready = 1;
    tick();
    chk("t1_rv_drop", rsp_valid, 0);
    chk("t1_idle", busy, 0);

    // ---- backpressure ----
    m_fix = 0; m_lat = 3; rsp_ready = 0;
    push_req(32'h11, 32'h0, 3'd0, 2'd1, 6'd10);
    push_req(32'h22, 32'h0, 3'd1, 2'd2, 6'd11);
    wait_rv(30);
    chk("t2_tag0", rsp_tag, 10);
    chk("t2_data0", rsp_data, 32'h12);
    s0 = n_start;
    ok = 1;
    repeat (10) begin
      tick();
      if (!rsp_valid || rsp_data !== 32'h12 || rsp_tag !== 6'd10 || rsp_flags !== 8'h00) ok = 0;
    end
    chk("t2_hold_stable", ok, 1);
    chk("t2_no_start", n_start - s0, 0);
    rsp_ready = 1;
    tick();
    h = hs_cyc;
    wait_start(10);
    chk("t2_reissue_gap", cyc - h, 2);
    chk("t2_op1", fpu_op, 3'd1);
    wait_rv(30);
    chk("t2_tag1", rsp_tag, 11);
    chk("t2_data1", rsp_data, 32'h23);
    tick();
    tick();
    chk("t2_idle", busy, 0);

    // ---- flags, and a ready pulse during ISSUE ----
    m_en = 0; rsp_ready = 0;
    push_req(32'h7F00_0000, 32'h7F00_0000, 3'd0, 2'd0, 6'd20);
    wait_start(10);
    fpu_ready = 1; fpu_result = 32'hDEAD_BEEF; fpu_flags = 8'hFF;
    tick();
    tick();
    tick();
    chk("t3_issue_ready_ignored", rsp_valid, 0);
    fpu_ready = 1; fpu_result = 32'h7F80_0000; fpu_flags = 8'h48;
    tick();
    chk("t3_rv", rsp_valid, 1);
    chk("t3_data", rsp_data, 32'h7F80_0000);
    chk("t3_flags", rsp_flags, 8'h48);
    chk("t3_tag", rsp_tag, 20);
    rsp_ready = 1;
    tick();
    tick();

    // ---- fill: four queued behind the in-flight op ----
    m_en = 1; m_fix = 0; m_flg = 0; m_lat = FILL_LAT; rsp_ready = 1;
    r0 = n_rsp;
    for (int t = 0; t < 5; t++) push_req(32'd100 + 32'(t), 32'h0, 3'd0, 2'd0, TAG_W'(t));
    chk("t4_full_ready", req_ready, 0);
    np = n_push;
    ok = 1;
    req_opa = 32'd999; req_tag = 6'd9; req_valid = 1;
    repeat (5) begin
      tick();
      if (req_ready) ok = 0;
    end
    req_valid = 0;
    chk("t4_full_held", ok, 1);
    chk("t4_no_push_full", n_push - np, 0);
    for (int i = 0; i < 600; i++) begin
      if (n_rsp - r0 >= 5) break;
      tick();
    end
    chk("t4_nrsp", n_rsp - r0, 5);
    for (int t = 0; t < 5; t++) begin
      chk($sformatf("t4_tag%0d", t), got_tag[r0 + t], t);
      chk($sformatf("t4_data%0d", t), got_data[r0 + t], 101 + t);
    end
    tick();
    chk("t4_idle", busy, 0);

    // ---- reset mid-WAIT with three queued ----
    m_en = 0; m_cnt = 0; rsp_ready = 0;
    for (int t = 0; t < 4; t++) push_req(32'h1234 + 32'(t), 32'h5, 3'd3, 2'd3, TAG_W'(40 + t));
    repeat (3) tick();
    chk("t5_busy_before", busy, 1);
    rst = 1;
    #1;
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_rsp_data", rsp_data, 0);
    chk("t5_rsp_tag", rsp_tag, 0);
    chk("t5_fpu_opa", fpu_opa, 0);
    chk("t5_fpu_op", fpu_op, 0);
    chk("t5_busy", busy, 0);
    chk("t5_req_ready", req_ready, 0);
    tick();
    rst = 0;
    tick();
    chk("t5_busy_after", busy, 0);
    chk("t5_req_ready_after", req_ready, 1);
    s0 = n_start;
    fpu_ready = 1; fpu_result = 32'hBAD0_0000;
    repeat (5) tick();
    chk("t5_stale_no_rsp", rsp_valid, 0);
    chk("t5_stale_idle", busy, 0);
    chk("t5_no_start", n_start - s0, 0);

`ifdef FPU_SEQ_TIMEOUT_EN
    // ---- watchdog abort, then the next op proceeds ----
    m_en = 0; rsp_ready = 0;
    push_req(32'd500, 32'h0, 3'd0, 2'd0, 6'd30);
    push_req(32'd600, 32'h0, 3'd0, 2'd0, 6'd31);
    wait_start(10);
    wait_rv(30);
    chk("t6_tmo_lat", cyc - last_start, 9);
    chk("t6_data", rsp_data, 32'h7FC0_0000);
    chk("t6_flags", rsp_flags, 8'h02);
    chk("t6_timeout", rsp_timeout, 1);
    chk("t6_tag", rsp_tag, 30);
    fpu_ready = 1; fpu_result = 32'h1111_1111;   // late answer while in RESP
    m_en = 1; m_lat = 3;
    tick();
    chk("t6_late_ignored", rsp_data, 32'h7FC0_0000);
    rsp_ready = 1;
    tick();
    wait_rv(30);
    chk("t6_next_tag", rsp_tag, 31);
    chk("t6_next_data", rsp_data, 32'd601);
    chk("t6_next_timeout", rsp_timeout, 0);
    tick();
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
